// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// sar_pkg : shared types and constants for the SAR conversion sequencer
// Revision: 1.0
// ============================================================================
package sar_pkg;

    localparam int   NBITS_DEFAULT = 16;
    localparam logic POL_RESET     = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAMPLE  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } sar_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_sequencer_if.sv
`default_nettype none
// ============================================================================
// sar_sequencer_if : start/comparator handshake and DAC drive bundle
// Revision: 1.0
// ============================================================================
interface sar_sequencer_if
    import sar_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
);
    logic             start;
    logic             comp_out;
    logic             comp_ack;
    logic             comp_req;
    logic             sample;
    logic [NBITS-1:0] dac_state;
    logic             dac_drive_invert;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] result;
    logic             err;

    // Sequencer side
    modport master (
        input  start, comp_out, comp_ack,
        output comp_req, sample, dac_state, dac_drive_invert,
        output busy, done, result, err
    );

    // Requester / comparator side
    modport slave (
        output start, comp_out, comp_ack,
        input  comp_req, sample, dac_state, dac_drive_invert,
        input  busy, done, result, err
    );
endinterface
`default_nettype wire

// File: rtl/sar_timer.sv
`default_nettype none
// ============================================================================
// sar_timer : loadable down-counter that stops at zero
// Revision: 1.0
// ============================================================================
module sar_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign value = r_count;
    assign zero  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/sar_sequencer.sv
`default_nettype none
// ============================================================================
// sar_sequencer : SAR ADC controller - sampling, per-bit settle/compare,
//                 comparator handshake with timeout, optional chopping
// Revision: 1.0
// ============================================================================
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int NBITS          = NBITS_DEFAULT,
    parameter int SAMPLE_CYCLES  = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CHOP_EN        = 0
) (
    input  logic            clk,
    input  logic            rst,
    sar_sequencer_if.master bus
);
    localparam int c_cnt_w = $clog2(max3(SAMPLE_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int c_ptr_w = (NBITS > 1) ? $clog2(NBITS) : 1;

    // Timer counts down to zero inclusive, so each phase loads its length minus one
    localparam logic [c_cnt_w-1:0] c_sample_load  = c_cnt_w'(SAMPLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_load  = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_load = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_msb      = c_ptr_w'(NBITS - 1);

    sar_state_e         r_state;
    logic [c_ptr_w-1:0] r_ptr;
    logic [NBITS-1:0]   r_dac;
    logic [NBITS-1:0]   r_result;
    logic               r_pol;
    logic               r_err;
    logic               r_sample;
    logic               r_comp_req;
    logic               r_busy;
    logic               r_done;

    logic               w_start_ok;
    logic               w_in_compare;
    logic               w_timeout;
    logic               w_decide;
    logic               w_d;
    logic [c_ptr_w-1:0] w_ptr_dec;
    logic [NBITS-1:0]   w_dac_decided;
    logic [NBITS-1:0]   w_dac_next;
    logic               w_tmr_load;
    logic [c_cnt_w-1:0] w_tmr_load_value;
    logic [c_cnt_w-1:0] w_tmr_value;
    logic               w_tmr_zero;

    sar_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_tmr_load),
        .load_value (w_tmr_load_value),
        .value      (w_tmr_value),
        .zero       (w_tmr_zero)
    );

    always_comb begin
        w_start_ok   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_in_compare = (r_state == ST_COMPARE);
        w_timeout    = w_in_compare && !bus.comp_ack && (w_tmr_value == '0);
        w_decide     = w_in_compare && (bus.comp_ack || w_timeout);

        // pol=0 means the drivers are inverted, so the comparator sense flips too;
        // a timed-out bit is resolved as 0
        w_d = bus.comp_ack & (bus.comp_out ~^ r_pol);

        w_ptr_dec            = r_ptr - 1'b1;
        w_dac_decided        = r_dac;
        w_dac_decided[r_ptr] = w_d;
        w_dac_next           = w_dac_decided;
        if (r_ptr != '0) begin
            w_dac_next[w_ptr_dec] = 1'b1;
        end

        w_tmr_load       = 1'b0;
        w_tmr_load_value = '0;
        if (w_start_ok) begin
            w_tmr_load       = 1'b1;
            w_tmr_load_value = c_sample_load;
        end else if (((r_state == ST_SAMPLE) && w_tmr_zero) || (w_decide && (r_ptr != '0))) begin
            w_tmr_load       = 1'b1;
            w_tmr_load_value = c_settle_load;
        end else if ((r_state == ST_SETTLE) && w_tmr_zero) begin
            w_tmr_load       = 1'b1;
            w_tmr_load_value = c_timeout_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_dac      <= '0;
            r_result   <= '0;
            r_pol      <= POL_RESET;
            r_err      <= 1'b0;
            r_sample   <= 1'b0;
            r_comp_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // Polarity only ever changes between conversions
                    if ((r_state == ST_DONE) && (CHOP_EN != 0)) begin
                        r_pol <= ~r_pol;
                    end
                    if (bus.start) begin
                        r_state  <= ST_SAMPLE;
                        r_dac    <= '0;
                        r_ptr    <= c_ptr_msb;
                        r_err    <= 1'b0;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_SAMPLE: begin
                    if (w_tmr_zero) begin
                        r_state           <= ST_SETTLE;
                        r_sample          <= 1'b0;
                        r_dac[NBITS-1]    <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state    <= ST_COMPARE;
                        r_comp_req <= 1'b1;
                    end
                end

                ST_COMPARE: begin
                    if (w_decide) begin
                        r_comp_req <= 1'b0;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                        if (r_ptr != '0) begin
                            r_state <= ST_SETTLE;
                            r_ptr   <= w_ptr_dec;
                            r_dac   <= w_dac_next;
                        end else begin
                            r_state  <= ST_DONE;
                            r_dac    <= w_dac_decided;
                            r_result <= w_dac_decided;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_sample   <= 1'b0;
                    r_comp_req <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.comp_req         = r_comp_req;
    assign bus.sample           = r_sample;
    assign bus.dac_state        = r_dac;
    assign bus.dac_drive_invert = r_pol;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.result           = r_result;
    assign bus.err              = r_err;
endmodule
`default_nettype wire

// File: tb/tb_sar_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sar_sequencer : directed bench for sar_sequencer with ideal comparators
// Revision: 1.0
// ============================================================================
module tb_sar_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    sar_sequencer_if #(.NBITS(16)) bus  ();
    sar_sequencer_if #(.NBITS(16)) cbus ();

    sar_sequencer #(
        .NBITS(16), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(15), .CHOP_EN(0)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    sar_sequencer #(
        .NBITS(16), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(15), .CHOP_EN(1)
    ) dut_chop (
        .clk(clk), .rst(rst), .bus(cbus)
    );

    always #5 clk = ~clk;

    // Comparator model knobs: input code, ack latency, bit whose ack is withheld
    logic [15:0] m_code  = 16'h0000;
    int          m_delay = 0;
    int          m_hold  = 99;
    int          m_wait  = 0;
    logic [15:0] c_code  = 16'h0000;

    function automatic int lowest_set(input logic [15:0] v);
        int r;
        r = -1;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    initial begin
        bus.comp_ack = 1'b0;
        bus.comp_out = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.comp_req === 1'b1) begin
                if ((m_wait >= m_delay) && (lowest_set(bus.dac_state) != m_hold)) begin
                    bus.comp_ack = 1'b1;
                    bus.comp_out = (m_code >= bus.dac_state) ~^ bus.dac_drive_invert;
                end else begin
                    bus.comp_ack = 1'b0;
                end
                m_wait++;
            end else begin
                bus.comp_ack = 1'b0;
                bus.comp_out = 1'b0;
                m_wait = 0;
            end
        end
    end

    initial begin
        cbus.comp_ack = 1'b0;
        cbus.comp_out = 1'b0;
        forever begin
            @(negedge clk);
            cbus.comp_ack = (cbus.comp_req === 1'b1);
            cbus.comp_out = (c_code >= cbus.dac_state) ~^ cbus.dac_drive_invert;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        cbus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Start in cycle 0, then observe cycles 1..max_cyc
    task automatic run_main(
        input  logic [15:0] code, input int delay, input int hold,
        input  bit hold_start, input int pulse_cyc, input int max_cyc,
        output int first_done, output int last_done, output int n_done,
        output logic [15:0] res, output logic err_v, output int inv_bad,
        output int samp_first, output int samp_cnt,
        output logic [15:0] dac_c5, output logic req_c7
    );
        m_code = code; m_delay = delay; m_hold = hold;
        first_done = 0; last_done = 0; n_done = 0; res = '0; err_v = 1'b0;
        inv_bad = 0; samp_first = 0; samp_cnt = 0; dac_c5 = '0; req_c7 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge clk);
            #1;
            if (!hold_start) bus.start = (cyc == pulse_cyc);
            if ((bus.sample === 1'b1) && (cyc <= 10)) begin
                samp_cnt++;
                if (samp_first == 0) samp_first = cyc;
            end
            if (cyc == 5) dac_c5 = bus.dac_state;
            if (cyc == 7) req_c7 = bus.comp_req;
            if ((bus.busy === 1'b1) && (bus.dac_drive_invert !== 1'b1)) inv_bad++;
            if (bus.done === 1'b1) begin
                n_done++;
                last_done = cyc;
                if (first_done == 0) begin
                    first_done = cyc;
                    res = bus.result;
                    err_v = bus.err;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic run_chop(input logic exp_inv, output logic [15:0] res,
                            output int inv_bad, output int done_cyc);
        res = '0; inv_bad = 0; done_cyc = 0;
        @(negedge clk);
        cbus.start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            cbus.start = 1'b0;
            if ((cbus.busy === 1'b1) && (cbus.dac_drive_invert !== exp_inv)) inv_bad++;
            if ((cbus.done === 1'b1) && (done_cyc == 0)) begin
                done_cyc = cyc;
                res = cbus.result;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.dac_state !== 16'h0000) begin bad++; $display("FAIL reset_dac: got %h want 0000", bus.dac_state); end
        total++; if (bus.result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", bus.result); end
        total++; if (bus.dac_drive_invert !== 1'b1) begin bad++; $display("FAIL reset_pol: got %b want 1", bus.dac_drive_invert); end
        total++; if (bus.sample !== 1'b0) begin bad++; $display("FAIL reset_sample: got %b want 0", bus.sample); end
        total++; if (bus.comp_req !== 1'b0) begin bad++; $display("FAIL reset_comp_req: got %b want 0", bus.comp_req); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        total++; if (cbus.dac_drive_invert !== 1'b1) begin bad++; $display("FAIL reset_chop_pol: got %b want 1", cbus.dac_drive_invert); end
    endtask

    task automatic test_ideal();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        run_main(16'hA5C3, 0, 99, 1'b0, 0, 70, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (sf != 1) begin bad++; $display("FAIL ideal_sample_start: got %0d want 1", sf); end
        total++; if (sc != 4) begin bad++; $display("FAIL ideal_sample_len: got %0d want 4", sc); end
        total++; if (d5 !== 16'h8000) begin bad++; $display("FAIL ideal_first_trial: got %h want 8000", d5); end
        total++; if (q7 !== 1'b1) begin bad++; $display("FAIL ideal_comp_req_c7: got %b want 1", q7); end
        total++; if (fd != 53) begin bad++; $display("FAIL ideal_done_cycle: got %0d want 53", fd); end
        total++; if (nd != 1) begin bad++; $display("FAIL ideal_done_count: got %0d want 1", nd); end
        total++; if (r !== 16'hA5C3) begin bad++; $display("FAIL ideal_result: got %h want a5c3", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ideal_err: got %b want 0", e); end
        total++; if (ib != 0) begin bad++; $display("FAIL ideal_pol_steady: got %0d bad cycles want 0", ib); end
    endtask

    task automatic test_timeout();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        run_main(16'hFFFF, 0, 7, 1'b0, 0, 80, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (fd != 67) begin bad++; $display("FAIL timeout_done_cycle: got %0d want 67", fd); end
        total++; if (r !== 16'hFF7F) begin bad++; $display("FAIL timeout_result: got %h want ff7f", r); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", e); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky: got %b want 1", bus.err); end
        // Next accepted start clears err; also covers the all-zero code
        run_main(16'h0000, 0, 99, 1'b0, 0, 60, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL timeout_err_clear: got %b want 0", e); end
        total++; if (r !== 16'h0000) begin bad++; $display("FAIL zero_result: got %h want 0000", r); end
        total++; if (fd != 53) begin bad++; $display("FAIL zero_done_cycle: got %0d want 53", fd); end
    endtask

    task automatic test_full_scale();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        run_main(16'hFFFF, 0, 99, 1'b0, 0, 60, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (r !== 16'hFFFF) begin bad++; $display("FAIL full_result: got %h want ffff", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL full_err: got %b want 0", e); end
    endtask

    task automatic test_ack_delay();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        run_main(16'h5A3C, 3, 99, 1'b0, 0, 110, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (fd != 101) begin bad++; $display("FAIL delay_done_cycle: got %0d want 101", fd); end
        total++; if (r !== 16'h5A3C) begin bad++; $display("FAIL delay_result: got %h want 5a3c", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL delay_err: got %b want 0", e); end
    endtask

    task automatic test_start_ignored();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        // Cycle 14 is the first settle cycle of bit 12
        run_main(16'h0F0F, 0, 99, 1'b0, 14, 120, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (nd != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
        total++; if (fd != 53) begin bad++; $display("FAIL ignore_done_cycle: got %0d want 53", fd); end
        total++; if (r !== 16'h0F0F) begin bad++; $display("FAIL ignore_result: got %h want 0f0f", r); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        m_code = 16'hBEEF; m_delay = 0; m_hold = 99;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        total++; if (bus.dac_state !== 16'hBC00) begin bad++; $display("FAIL rst_mid_partial: got %h want bc00", bus.dac_state); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.dac_state !== 16'h0000) begin bad++; $display("FAIL rst_mid_dac: got %h want 0000", bus.dac_state); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
        total++; if (bus.comp_req !== 1'b0) begin bad++; $display("FAIL rst_mid_comp_req: got %b want 0", bus.comp_req); end
        total++; if (bus.sample !== 1'b0) begin bad++; $display("FAIL rst_mid_sample: got %b want 0", bus.sample); end
        total++; if (bus.dac_drive_invert !== 1'b1) begin bad++; $display("FAIL rst_mid_pol: got %b want 1", bus.dac_drive_invert); end
        total++; if ((bus.done !== 1'b0) || (bus.err !== 1'b0) || (bus.result !== 16'h0000)) begin
            bad++; $display("FAIL rst_mid_done_err_result: got %b %b %h want 0 0 0000", bus.done, bus.err, bus.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int fd, ld, nd, ib, sf, sc; logic [15:0] r, d5; logic e, q7;
        do_reset();
        run_main(16'h3C5A, 0, 99, 1'b1, 0, 160, fd, ld, nd, r, e, ib, sf, sc, d5, q7);
        total++; if (nd != 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
        total++; if (fd != 53) begin bad++; $display("FAIL b2b_first_done: got %0d want 53", fd); end
        total++; if (ld != 159) begin bad++; $display("FAIL b2b_last_done: got %0d want 159", ld); end
        total++; if (r !== 16'h3C5A) begin bad++; $display("FAIL b2b_result: got %h want 3c5a", r); end
        do_reset();
    endtask

    task automatic test_chop();
        logic [15:0] r; int ib, dc;
        do_reset();
        c_code = 16'h1234;
        run_chop(1'b1, r, ib, dc);
        total++; if (r !== 16'h1234) begin bad++; $display("FAIL chop1_result: got %h want 1234", r); end
        total++; if (ib != 0) begin bad++; $display("FAIL chop1_pol: got %0d bad cycles want 0", ib); end
        total++; if (dc != 53) begin bad++; $display("FAIL chop1_done_cycle: got %0d want 53", dc); end
        total++; if (cbus.dac_drive_invert !== 1'b0) begin bad++; $display("FAIL chop1_pol_after: got %b want 0", cbus.dac_drive_invert); end
        run_chop(1'b0, r, ib, dc);
        total++; if (r !== 16'h1234) begin bad++; $display("FAIL chop2_result: got %h want 1234", r); end
        total++; if (ib != 0) begin bad++; $display("FAIL chop2_pol: got %0d bad cycles want 0", ib); end
        total++; if (cbus.dac_drive_invert !== 1'b1) begin bad++; $display("FAIL chop2_pol_after: got %b want 1", cbus.dac_drive_invert); end
        run_chop(1'b1, r, ib, dc);
        total++; if (cbus.dac_drive_invert !== 1'b0) begin bad++; $display("FAIL chop3_pol_after: got %b want 0", cbus.dac_drive_invert); end
        do_reset();
        total++; if (cbus.dac_drive_invert !== 1'b1) begin bad++; $display("FAIL chop_rst_pol: got %b want 1", cbus.dac_drive_invert); end
    endtask

    initial begin
        bus.start  = 1'b0;
        cbus.start = 1'b0;
        test_reset();
        test_ideal();
        test_timeout();
        test_full_scale();
        test_ack_delay();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        test_chop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
